// File: rtl/axis_packet_arbiter.sv
// Packet-locked AXI-Stream arbiter: shares one sink between NUM_INPUTS sources,
// using round-robin or fixed-priority selection gated by a per-input enable mask.
module axis_packet_arbiter #(
  parameter int NUM_INPUTS     = 2,
  parameter int AXIS_BYTES     = 1,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                               clk,
  input  logic                               sresetn,
  input  logic [NUM_INPUTS-1:0]              en,
  output logic [NUM_INPUTS-1:0]              s_axis_tready,
  input  logic [NUM_INPUTS-1:0]              s_axis_tvalid,
  input  logic [NUM_INPUTS-1:0]              s_axis_tlast,
  input  logic [NUM_INPUTS*AXIS_BYTES*8-1:0] s_axis_tdata,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tvalid,
  output logic                               m_axis_tlast,
  output logic [AXIS_BYTES*8-1:0]            m_axis_tdata,
  output logic [NUM_INPUTS-1:0]              grant,
  output logic                               busy
);

  localparam int          W     = AXIS_BYTES * 8;
  localparam int          IDX_W = $clog2(NUM_INPUTS);
  localparam int unsigned N_U   = NUM_INPUTS;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]            state;
  logic [IDX_W-1:0]      last_idx;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      win_idx;
  logic [NUM_INPUTS-1:0] req;
  logic [NUM_INPUTS-1:0] win_onehot;
  logic                  win_found;
  logic                  end_of_packet;
  int unsigned           cand;

  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < N_U; i++) begin
      if (grant[IDX_W'(i)]) grant_idx = IDX_W'(i);
    end
  end

  // Scans run from lowest to highest priority so the last hit is the winner.
  always_comb begin
    req       = s_axis_tvalid & en;
    win_idx   = '0;
    win_found = 1'b0;
    cand      = 0;
    if (FIXED_PRIORITY != 0) begin
      for (int unsigned i = N_U; i > 0; i--) begin
        if (req[IDX_W'(i - 1)]) begin
          win_idx   = IDX_W'(i - 1);
          win_found = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = N_U; k > 0; k--) begin
        cand = (32'(last_idx) + k) % N_U;
        if (req[IDX_W'(cand)]) begin
          win_idx   = IDX_W'(cand);
          win_found = 1'b1;
        end
      end
    end
    win_onehot = win_found ? (NUM_INPUTS'(1) << win_idx) : '0;
  end

  // grant is zero outside GRANT, so the AND-OR mux also drives zeros when idle.
  always_comb begin
    s_axis_tready = grant & {NUM_INPUTS{m_axis_tready}};
    m_axis_tvalid = |(grant & s_axis_tvalid);
    m_axis_tlast  = |(grant & s_axis_tlast);
    m_axis_tdata  = '0;
    for (int unsigned i = 0; i < N_U; i++) begin
      if (grant[IDX_W'(i)]) m_axis_tdata = m_axis_tdata | s_axis_tdata[i*W +: W];
    end
  end

  assign end_of_packet = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign busy          = (state == GRANT);

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state    <= IDLE;
      grant    <= '0;
      last_idx <= IDX_W'(NUM_INPUTS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            grant <= win_onehot;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (end_of_packet) begin
            last_idx <= grant_idx;
            grant    <= '0;
            state    <= IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Bench for axis_packet_arbiter: a round-robin and a fixed-priority instance,
// each fed by queue-based sources and checked against a per-cycle owner model.
module tb_axis_packet_arbiter;

  localparam int NI = 2;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         cyc;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  en     [2];
  logic [1:0]  valid  [2];
  logic [1:0]  last   [2];
  logic [15:0] data   [2];
  logic        mready [2];

  logic [1:0] rdy_rr, rdy_fp, gnt_rr, gnt_fp;
  logic       mv_rr, mv_fp, ml_rr, ml_fp, busy_rr, busy_fp;
  logic [7:0] md_rr, md_fp;

  axis_packet_arbiter #(.NUM_INPUTS(2), .AXIS_BYTES(1), .FIXED_PRIORITY(0)) u_rr (
    .clk(clk), .sresetn(rst_n), .en(en[0]), .s_axis_tready(rdy_rr),
    .s_axis_tvalid(valid[0]), .s_axis_tlast(last[0]), .s_axis_tdata(data[0]),
    .m_axis_tready(mready[0]), .m_axis_tvalid(mv_rr), .m_axis_tlast(ml_rr),
    .m_axis_tdata(md_rr), .grant(gnt_rr), .busy(busy_rr)
  );

  axis_packet_arbiter #(.NUM_INPUTS(2), .AXIS_BYTES(1), .FIXED_PRIORITY(1)) u_fp (
    .clk(clk), .sresetn(rst_n), .en(en[1]), .s_axis_tready(rdy_fp),
    .s_axis_tvalid(valid[1]), .s_axis_tlast(last[1]), .s_axis_tdata(data[1]),
    .m_axis_tready(mready[1]), .m_axis_tvalid(mv_fp), .m_axis_tlast(ml_fp),
    .m_axis_tdata(md_fp), .grant(gnt_fp), .busy(busy_fp)
  );

  logic [8:0] srcq [2][2][$];
  beat_t      logq [2][$];
  int         owner [2];
  int         lastw [2];
  int         cyc = 0;
  int         checks = 0;
  int         fails = 0;

  function automatic logic [1:0] d_grant(int d); return d == 0 ? gnt_rr : gnt_fp; endfunction
  function automatic logic [1:0] d_ready(int d); return d == 0 ? rdy_rr : rdy_fp; endfunction
  function automatic logic d_mvalid(int d); return d == 0 ? mv_rr : mv_fp; endfunction
  function automatic logic d_mlast(int d); return d == 0 ? ml_rr : ml_fp; endfunction
  function automatic logic d_busy(int d); return d == 0 ? busy_rr : busy_fp; endfunction
  function automatic logic [7:0] d_mdata(int d); return d == 0 ? md_rr : md_fp; endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NI; i++) begin
        if (srcq[d][i].size() > 0) begin
          valid[d][i]       = 1'b1;
          data[d][i*8 +: 8] = srcq[d][i][0][7:0];
          last[d][i]        = srcq[d][i][0][8];
        end else begin
          valid[d][i]       = 1'b0;
          data[d][i*8 +: 8] = 8'h00;
          last[d][i]        = 1'b0;
        end
      end
  endtask

  task automatic push(int d, int i, logic [7:0] b, logic l);
    srcq[d][i].push_back({l, b});
  endtask

  // Expected outputs follow directly from who owns the sink this cycle.
  task automatic compare();
    for (int d = 0; d < 2; d++) begin
      logic [1:0] eg;
      logic       ev;
      eg = owner[d] < 0 ? 2'b00 : 2'(1 << owner[d]);
      ev = owner[d] < 0 ? 1'b0 : valid[d][owner[d]];
      chk($sformatf("grant[%0d]", d), d_grant(d), eg);
      chk($sformatf("busy[%0d]", d), d_busy(d), owner[d] >= 0);
      chk($sformatf("mvalid[%0d]", d), d_mvalid(d), ev);
      chk($sformatf("sready[%0d]", d), d_ready(d), mready[d] ? eg : 2'b00);
      if (ev) begin
        chk($sformatf("mlast[%0d]", d), d_mlast(d), last[d][owner[d]]);
        chk($sformatf("mdata[%0d]", d), d_mdata(d), data[d][owner[d]*8 +: 8]);
      end
      if (d_mvalid(d) && mready[d])
        logq[d].push_back('{data: d_mdata(d), last: d_mlast(d), cyc: cyc});
    end
  endtask

  task automatic model_update();
    if (!rst_n) return;
    for (int d = 0; d < 2; d++) begin
      if (owner[d] < 0) begin
        logic [1:0] req;
        req = valid[d] & en[d];
        if (req != 0) begin
          if (d == 1) begin
            owner[d] = req[0] ? 0 : 1;
          end else begin
            for (int k = 1; k <= NI; k++)
              if (owner[d] < 0 && req[(lastw[d] + k) % NI]) owner[d] = (lastw[d] + k) % NI;
          end
        end
      end else if (valid[d][owner[d]] && mready[d] && last[d][owner[d]]) begin
        lastw[d] = owner[d];
        owner[d] = -1;
      end
    end
  endtask

  task automatic step();
    logic [1:0] hs [2];
    @(negedge clk);
    compare();
    hs[0] = valid[0] & rdy_rr;
    hs[1] = valid[1] & rdy_fp;
    @(posedge clk);
    cyc++;
    model_update();
    #1;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NI; i++)
        if (hs[d][i] && srcq[d][i].size() > 0) void'(srcq[d][i].pop_front());
    drive();
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      owner[d] = -1;
      lastw[d] = NI - 1;
      for (int i = 0; i < NI; i++) srcq[d][i].delete();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    drive();
    step();
    step();
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) logq[d].delete();
  endtask

  task automatic wait_idle(string name, int budget);
    int n = 0;
    while ((srcq[0][0].size() + srcq[0][1].size() + srcq[1][0].size() + srcq[1][1].size() != 0 ||
            owner[0] >= 0 || owner[1] >= 0) && n < budget) begin
      step();
      n++;
    end
    step();
    chk({name, "_timeout"}, n >= budget, 0);
  endtask

  task automatic chk_log(int d, string name, logic [7:0] exp[$]);
    chk({name, "_len"}, logq[d].size(), exp.size());
    for (int k = 0; k < exp.size() && k < logq[d].size(); k++)
      chk($sformatf("%s_beat%0d", name, k), logq[d][k].data, exp[k]);
  endtask

  initial begin
    logic [7:0] e[$];
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      en[d]     = 2'b11;
      mready[d] = 1'b1;
    end
    model_reset();
    drive();
    push(0, 0, 8'h41, 1'b0);
    push(1, 1, 8'h42, 1'b1);
    drive();
    #2;
    chk("rst_grant", gnt_rr, 2'b00);
    chk("rst_busy", busy_rr, 1'b0);
    chk("rst_ready", {rdy_rr, rdy_fp}, 4'b0000);
    chk("rst_mvalid", {mv_rr, mv_fp}, 2'b00);
    chk("rst_mdata", {md_rr, md_fp}, 16'h0000);
    do_reset();

    // Single source, three-byte packet.
    push(0, 0, 8'h41, 1'b0); push(0, 0, 8'h42, 1'b0); push(0, 0, 8'h43, 1'b1);
    drive();
    step();
    chk("t1_grant_after_1", gnt_rr, 2'b01);
    step(); step();
    chk("t1_grant_after_3", gnt_rr, 2'b01);
    step();
    chk("t1_grant_after_4", gnt_rr, 2'b00);
    wait_idle("t1", 20);
    e = '{8'h41, 8'h42, 8'h43};
    chk_log(0, "t1", e);
    if (logq[0].size() == 3) begin
      chk("t1_lastflags", {logq[0][0].last, logq[0][1].last, logq[0][2].last}, 3'b001);
      chk("t1_gap01", logq[0][1].cyc - logq[0][0].cyc, 1);
      chk("t1_gap12", logq[0][2].cyc - logq[0][1].cyc, 1);
    end

    // Round-robin fairness with continuously valid two-byte packets.
    do_reset();
    for (int p = 0; p < 3; p++) begin
      push(0, 0, 8'hA0, 1'b0); push(0, 0, 8'hA1, 1'b1);
      push(0, 1, 8'hB0, 1'b0); push(0, 1, 8'hB1, 1'b1);
    end
    drive();
    wait_idle("t2", 60);
    e = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA0, 8'hA1, 8'hB0, 8'hB1};
    chk_log(0, "t2", e);
    for (int k = 1; k < logq[0].size(); k++)
      chk($sformatf("t2_gap%0d", k), logq[0][k].cyc - logq[0][k-1].cyc, (k % 2 == 0) ? 2 : 1);

    // Packet lock under sink backpressure.
    do_reset();
    push(0, 1, 8'hB0, 1'b0); push(0, 1, 8'hB1, 1'b0); push(0, 1, 8'hB2, 1'b1);
    drive();
    step(); step();
    push(0, 0, 8'h55, 1'b1);
    mready[0] = 1'b0;
    drive();
    step(); step();
    chk("t3_grant_stalled", gnt_rr, 2'b10);
    mready[0] = 1'b1;
    drive();
    wait_idle("t3", 30);
    e = '{8'hB0, 8'hB1, 8'hB2, 8'h55};
    chk_log(0, "t3", e);

    // Enable mask gates new grants only.
    do_reset();
    en[0] = 2'b10;
    push(0, 0, 8'h55, 1'b1);
    drive();
    repeat (4) step();
    chk("t4_masked_grant", gnt_rr, 2'b00);
    chk("t4_masked_ready0", rdy_rr[0], 1'b0);
    chk("t4_masked_log", logq[0].size(), 0);
    en[0] = 2'b11;
    drive();
    step();
    chk("t4_enabled_grant", gnt_rr, 2'b01);
    wait_idle("t4a", 20);
    push(0, 1, 8'hC0, 1'b0); push(0, 1, 8'hC1, 1'b1);
    drive();
    step(); step();
    en[0] = 2'b01;
    drive();
    wait_idle("t4b", 20);
    en[0] = 2'b11;
    e = '{8'h55, 8'hC0, 8'hC1};
    chk_log(0, "t4", e);

    // Single-beat packets: fixed priority versus per-beat round-robin.
    do_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) push(d, 0, 8'(8'h10 + k), 1'b1);
      push(d, 1, 8'h20, 1'b1); push(d, 1, 8'h21, 1'b1);
    end
    drive();
    wait_idle("t5", 60);
    e = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21};
    chk_log(1, "t5_fp", e);
    e = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h13};
    chk_log(0, "t5_rr", e);

    // Asynchronous reset between beats 2 and 3.
    do_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) push(d, 0, 8'(8'hD0 + k), k == 3);
      push(d, 1, 8'hE0, 1'b1);
    end
    drive();
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_grant", {gnt_rr, gnt_fp}, 4'b0000);
    chk("t6_rst_busy", {busy_rr, busy_fp}, 2'b00);
    chk("t6_rst_ready", {rdy_rr, rdy_fp}, 4'b0000);
    chk("t6_rst_mvalid", {mv_rr, mv_fp}, 2'b00);
    model_reset();
    drive();
    step();
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) logq[d].delete();
    for (int d = 0; d < 2; d++) begin
      push(d, 0, 8'h61, 1'b1);
      push(d, 1, 8'h71, 1'b1);
    end
    drive();
    step();
    chk("t6_first_grant", {gnt_rr, gnt_fp}, 4'b0101);
    wait_idle("t6", 20);
    e = '{8'h61, 8'h71};
    chk_log(0, "t6", e);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/axis_packet_arbiter.md
Name: axis_packet_arbiter

Overview:
- Shares one AXI-Stream sink (typically the uart_tx input) between NUM_INPUTS AXI-Stream sources: version banner, serial_wb_master responses, boot_manager status, and so on.
- Packet-locked: once granted, a source owns the sink until its tlast beat completes.
- Selection is round-robin, or fixed priority when configured.
- A per-input enable mask gates which sources may win arbitration. This replaces the ad-hoc ternary muxing currently done at top level.

Parameters:
- NUM_INPUTS, 2, number of source ports; legal range 2..8.
- AXIS_BYTES, 1, tdata width in bytes per port.
- FIXED_PRIORITY, 0, 0 = round-robin; 1 = lowest index always wins.

Ports:
- clk  in  1  system clock.
- sresetn  in  1  reset; asynchronous assert, active-low.
- en  in  NUM_INPUTS  per-input arbitration enable; bit i=0 means input i cannot win a new grant.
- s_axis_tready  out  NUM_INPUTS  per-input ready.
- s_axis_tvalid  in  NUM_INPUTS  per-input valid.
- s_axis_tlast  in  NUM_INPUTS  per-input end of packet.
- s_axis_tdata  in  NUM_INPUTS*AXIS_BYTES*8  packed data; input i occupies bits [i*W +: W], where W = AXIS_BYTES*8.
- m_axis_tready  in  1  sink ready.
- m_axis_tvalid  out  1  sink valid.
- m_axis_tlast  out  1  sink end of packet.
- m_axis_tdata  out  AXIS_BYTES*8  sink data.
- grant  out  NUM_INPUTS  one-hot owner of the sink; all zero when idle.
- busy  out  1  high while in GRANT state.

Behaviour:
- State machine has two states, IDLE and GRANT. Registers: state, grant (one-hot), last_idx ($clog2(NUM_INPUTS) bits).
- Reset values (asynchronous, while sresetn=0):
  - state=IDLE, grant=0, busy=0.
  - last_idx=NUM_INPUTS-1, so input 0 is first in round-robin order.
  - All s_axis_tready=0, m_axis_tvalid=0.
  - m_axis_tlast and m_axis_tdata are don't-care, but are driven 0 when grant=0.
- IDLE:
  - req = s_axis_tvalid & en.
  - If req≠0, pick a winner:
    - Round-robin: first set req bit scanning upward from (last_idx+1) mod NUM_INPUTS, with wrap-around.
    - FIXED_PRIORITY=1: lowest set bit.
  - Register the winner into grant and go to GRANT.
  - In IDLE, all s_axis_tready=0 and m_axis_tvalid=0; no data is accepted.
- GRANT, with g = granted index:
  - Combinational passthrough: m_axis_tvalid=s_axis_tvalid[g], m_axis_tlast=s_axis_tlast[g], m_axis_tdata=slice g, s_axis_tready[g]=m_axis_tready.
  - All other s_axis_tready=0.
  - On the handshake beat (tvalid&tready) with tlast=1: last_idx<=g, grant<=0, go to IDLE.
- Latency:
  - One cycle from req asserted in IDLE to first beat possible.
  - Exactly one idle bubble cycle between consecutive packets, even from the same source.
  - No throughput loss within a packet.
- en is sampled only in IDLE. Deasserting en[g] during GRANT does not abort the packet; the packet completes normally.
- s_axis_tvalid dropping mid-packet while granted: hold the grant, with m_axis_tvalid=0, until the tlast handshake.
- Sources that tie tlast=1 get per-beat round-robin interleaving.
- Reset mid-packet: immediate return to IDLE; the partial packet is abandoned. Sources must tolerate this, as the whole design resets together.
- The block never reorders, duplicates or drops beats. m_axis_tvalid must not deassert without a handshake while the granted source holds tvalid, per AXIS.

Test Plan:
- Single source: NUM_INPUTS=2, en=2'b11, input 0 sends 3 bytes 0x41,0x42,0x43 with tlast on 0x43, m_axis_tready=1 → grant=2'b01 one cycle after tvalid; output 0x41,0x42,0x43 on consecutive cycles, tlast on the third; grant=0 on the next cycle.
- Round-robin fairness: both inputs continuously valid with 2-byte packets (input0 0xA0,0xA1; input1 0xB0,0xB1) → output order A0 A1 B0 B1 A0 A1 …, with exactly one bubble between packets.
- Packet lock under backpressure: input1 granted mid-packet, m_axis_tready toggles 1,0,0,1, and input0 becomes valid → no input0 beat appears until input1's tlast handshake; input0 is granted next.
- Enable mask: en=2'b10 with input0 valid 0x55 → input0 never granted and s_axis_tready[0] stays 0; raising en[0] → input0 granted one cycle later. Clearing en[1] mid-packet → input1's packet still completes.
- FIXED_PRIORITY=1: both valid, single-beat packets → input0 always wins while valid; input1 is served only when input0 tvalid=0.
- Reset mid-packet: assert sresetn=0 between beats 2 and 3 → asynchronously grant=0, busy=0, all tready=0, m_axis_tvalid=0; after release with both inputs valid, input0 is granted first.
